// File: rtl/freq_meas_ctrl.sv
// freq_meas_ctrl: gate-timing controller for a reciprocal frequency counter.
// It sequences clear / gate / close / settle / evaluate around an external
// counter datapath, with optional auto-ranging of the gate length and a
// continuous mode. All outputs are registered from the next-state decode,
// so each output changes on the same edge as the state it belongs to.
module freq_meas_ctrl #(
  parameter int unsigned GATE_UNIT  = 2_000_000,
  parameter int unsigned TIMEOUT    = 400_000_000,
  parameter int unsigned SETTLE_CYC = 16,
  parameter int unsigned MIN_CNT    = 1000
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        cont,
  input  logic        auto_range,
  input  logic [1:0]  gate_sel,
  input  logic        real_gate,
  input  logic [31:0] sig_cnt,
  input  logic [31:0] ref_cnt,
  output logic        cnt_clr,
  output logic        ref_gate,
  output logic        busy,
  output logic        done,
  output logic        timeout_err,
  output logic [31:0] sig_cnt_out,
  output logic [31:0] ref_cnt_out,
  output logic [1:0]  gate_idx_out
);

  typedef enum logic [2:0] {IDLE, CLEAR, GATE, CLOSE, SETTLE, EVAL, ERR} state_t;

  localparam logic [31:0] GATE_UNIT_W  = 32'(GATE_UNIT);
  localparam logic [31:0] TIMEOUT_W    = 32'(TIMEOUT);
  localparam logic [31:0] SETTLE_CYC_W = 32'(SETTLE_CYC);
  localparam logic [31:0] MIN_CNT_W    = 32'(MIN_CNT);

  state_t      state, state_nx;
  logic [31:0] cyc_cnt;
  logic [31:0] gate_len;
  logic [1:0]  gate_idx, gate_idx_nx;
  logic        cont_q, cont_nx;
  logic        auto_q, auto_nx;
  logic        start_ok;
  logic        retry;
  logic        take;

  // Gate length grows by x4 per index step.
  assign gate_len = GATE_UNIT_W << {gate_idx, 1'b0};

  // A start coinciding with a done pulse or a stop request is dropped.
  assign start_ok = start && !stop && !done;
  assign retry    = auto_q && (sig_cnt < MIN_CNT_W) && (gate_idx != 2'd3);
  assign take     = (state == EVAL) && !stop && !retry;

  // Next-state logic; stop overrides every other transition out of a busy state.
  always_comb begin
    state_nx    = state;
    gate_idx_nx = gate_idx;
    cont_nx     = cont_q;
    auto_nx     = auto_q;
    case (state)
      IDLE: begin
        if (start_ok) begin
          cont_nx     = cont;
          auto_nx     = auto_range;
          gate_idx_nx = auto_range ? 2'd0 : gate_sel;
          state_nx    = CLEAR;
        end
      end
      CLEAR: state_nx = GATE;
      GATE: begin
        if (cyc_cnt == gate_len - 32'd1) state_nx = CLOSE;
      end
      CLOSE: begin
        if (!real_gate)                       state_nx = SETTLE;
        else if (cyc_cnt == TIMEOUT_W - 32'd1) state_nx = ERR;
      end
      SETTLE: begin
        if (cyc_cnt == SETTLE_CYC_W - 32'd1) state_nx = EVAL;
      end
      EVAL: begin
        if (retry) begin
          gate_idx_nx = gate_idx + 2'd1;
          state_nx    = CLEAR;
        end else if (cont_q) begin
          if (auto_q) gate_idx_nx = 2'd0;
          state_nx = CLEAR;
        end else begin
          state_nx = IDLE;
        end
      end
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (stop && (state != IDLE)) state_nx = IDLE;
  end

  // State register, latched mode bits and the shared per-state cycle counter.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      gate_idx <= 2'd0;
      cont_q   <= 1'b0;
      auto_q   <= 1'b0;
      cyc_cnt  <= '0;
    end else begin
      state    <= state_nx;
      gate_idx <= gate_idx_nx;
      cont_q   <= cont_nx;
      auto_q   <= auto_nx;
      cyc_cnt  <= (state_nx != state || state == IDLE) ? '0 : cyc_cnt + 32'd1;
    end
  end

  // Registered outputs decoded from the next state; captured counts hold until the next result.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      cnt_clr      <= 1'b0;
      ref_gate     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      timeout_err  <= 1'b0;
      sig_cnt_out  <= '0;
      ref_cnt_out  <= '0;
      gate_idx_out <= 2'd0;
    end else begin
      cnt_clr  <= (state_nx == CLEAR);
      ref_gate <= (state_nx == GATE);
      busy     <= (state_nx != IDLE);
      done     <= take;
      if (take) begin
        sig_cnt_out  <= sig_cnt;
        ref_cnt_out  <= ref_cnt;
        gate_idx_out <= gate_idx;
      end
      if ((state == IDLE) && start_ok) timeout_err <= 1'b0;
      else if (state_nx == ERR)        timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// tb_freq_meas_ctrl: self-checking bench for freq_meas_ctrl with a small
// counter-datapath model, a table of measurement vectors, randomized
// measurements against an arithmetic reference, and hand-written corner cases.
module tb_freq_meas_ctrl;

  localparam int GATE_UNIT  = 8;
  localparam int TIMEOUT    = 32;
  localparam int SETTLE_CYC = 4;
  localparam int MIN_CNT    = 100;

  logic        sys_clk, rst_n, start, stop, cont, auto_range, real_gate;
  logic [1:0]  gate_sel;
  logic [31:0] sig_cnt, ref_cnt;
  logic        cnt_clr, ref_gate, busy, done, timeout_err;
  logic [31:0] sig_cnt_out, ref_cnt_out;
  logic [1:0]  gate_idx_out;

  int n_vec, n_bad;

  int         sig_tab[4];
  int         rg_delay;
  logic       force_rg;
  logic [3:0] rg_hist;
  int         dp_len;

  int   cur_len, clr_cnt, done_cnt, clr_order_bad;
  logic prev_clr;
  int   win_q[$];

  typedef struct {
    logic [1:0] gsel;
    logic       au;
    int         s0, s1, s2, s3;
    int         exp_idx;
    int         exp_sig;
    int         exp_win;
  } vec_t;

  vec_t vecs[8];

  freq_meas_ctrl #(
    .GATE_UNIT(GATE_UNIT), .TIMEOUT(TIMEOUT), .SETTLE_CYC(SETTLE_CYC), .MIN_CNT(MIN_CNT)
  ) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .start(start), .stop(stop), .cont(cont),
    .auto_range(auto_range), .gate_sel(gate_sel), .real_gate(real_gate),
    .sig_cnt(sig_cnt), .ref_cnt(ref_cnt), .cnt_clr(cnt_clr), .ref_gate(ref_gate),
    .busy(busy), .done(done), .timeout_err(timeout_err), .sig_cnt_out(sig_cnt_out),
    .ref_cnt_out(ref_cnt_out), .gate_idx_out(gate_idx_out)
  );

  // Free-running system clock.
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Hard stop in case a wait loop is miscoded.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time exhausted");
    $fatal(1, "[TB] watchdog");
  end

  // Gate length of an index, computed from the x4-per-step rule.
  function automatic int glen(input int idx);
    int len = GATE_UNIT;
    repeat (idx) len = len * 4;
    return len;
  endfunction

  // Reference model: the gate index whose result ends up reported.
  function automatic int model_idx(input logic au, input logic [1:0] gs);
    if (!au) return int'(gs);
    for (int i = 0; i < 3; i++) if (sig_tab[i] >= MIN_CNT) return i;
    return 3;
  endfunction

  // Datapath model: counts gate cycles, delays the gate and reports a count per window size.
  always @(negedge sys_clk) begin
    int k;
    if (cnt_clr) dp_len = 0;
    else if (ref_gate) dp_len = dp_len + 1;
    rg_hist   = {rg_hist[2:0], ref_gate};
    real_gate = force_rg | rg_hist[rg_delay];
    k = 0;
    for (int i = 1; i < 4; i++) if (dp_len >= glen(i)) k = i;
    sig_cnt = 32'(sig_tab[k]);
    ref_cnt = 32'(dp_len);
  end

  // Monitor: gate window lengths, clear pulses, done pulses and clear-before-gate ordering.
  always @(negedge sys_clk) begin
    if (ref_gate) begin
      if (cur_len == 0 && !prev_clr) clr_order_bad = clr_order_bad + 1;
      cur_len = cur_len + 1;
    end else if (cur_len > 0) begin
      win_q.push_back(cur_len);
      cur_len = 0;
    end
    if (cnt_clr) clr_cnt = clr_cnt + 1;
    if (done) done_cnt = done_cnt + 1;
    prev_clr = cnt_clr;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic bound_expired(input string name);
    n_vec = n_vec + 1;
    n_bad = n_bad + 1;
    $display("[TB] FAIL %s: wait bound expired, got timeout, expected event", name);
  endtask

  task automatic clear_mon();
    win_q.delete();
    clr_cnt       = 0;
    done_cnt      = 0;
    clr_order_bad = 0;
  endtask

  // Pulse start for one cycle; called #1 after a rising edge.
  task automatic apply_stimulus(input logic [1:0] gs, input logic au, input logic ct);
    gate_sel   = gs;
    auto_range = au;
    cont       = ct;
    start      = 1'b1;
    @(posedge sys_clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done_cnt == 0 && n < 3000) begin
      @(negedge sys_clk);
      n++;
    end
    if (done_cnt == 0) bound_expired(name);
    repeat (3) @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_level(input logic lvl, input string name);
    int n = 0;
    while (ref_gate !== lvl && n < 1000) begin
      @(negedge sys_clk);
      n++;
    end
    if (ref_gate !== lvl) bound_expired(name);
  endtask

  // One complete single-shot measurement checked against expected results.
  task automatic run_vector(input string tag, input logic [1:0] gs, input logic au,
                            input int exp_idx, input int exp_sig, input int exp_win);
    int first;
    first = au ? 0 : int'(gs);
    clear_mon();
    apply_stimulus(gs, au, 1'b0);
    wait_done({tag, "_wait"});
    check_output({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check_output({tag, "_idx"}, 32'(gate_idx_out), 32'(exp_idx));
    check_output({tag, "_sig"}, sig_cnt_out, 32'(exp_sig));
    check_output({tag, "_ref"}, ref_cnt_out, 32'(glen(exp_idx)));
    check_output({tag, "_windows"}, 32'(win_q.size()), 32'(exp_win));
    for (int i = 0; i < win_q.size() && i < exp_win; i++)
      check_output({tag, "_win_len"}, 32'(win_q[i]), 32'(glen(first + i)));
    check_output({tag, "_clr_cnt"}, 32'(clr_cnt), 32'(exp_win));
    check_output({tag, "_clr_order"}, 32'(clr_order_bad), 32'd0);
    check_output({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int   n, d_before;
    logic [1:0] gs;
    logic au;

    n_vec = 0; n_bad = 0;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; cont = 1'b0; auto_range = 1'b0;
    gate_sel = 2'd0; real_gate = 1'b0; sig_cnt = '0; ref_cnt = '0;
    force_rg = 1'b0; rg_delay = 0; rg_hist = '0; dp_len = 0;
    cur_len = 0; prev_clr = 1'b0;
    for (int i = 0; i < 4; i++) sig_tab[i] = 0;
    clear_mon();

    vecs[0] = '{2'd2, 1'b0, 500, 500, 500, 500, 2, 500, 1};
    vecs[1] = '{2'd0, 1'b1,  10,  10, 200,   0, 2, 200, 3};
    vecs[2] = '{2'd1, 1'b1,   0,   0,   0,   0, 3,   0, 4};
    vecs[3] = '{2'd0, 1'b0,   5,   5,   5,   5, 0,   5, 1};
    vecs[4] = '{2'd3, 1'b0,   7,   7,   7,   7, 3,   7, 1};
    vecs[5] = '{2'd2, 1'b1, 100,   0,   0,   0, 0, 100, 1};
    vecs[6] = '{2'd0, 1'b1,  99, 100,   0,   0, 1, 100, 2};
    vecs[7] = '{2'd3, 1'b1,   0,   0,   0,  42, 3,  42, 4};

    // Reset state.
    repeat (3) @(posedge sys_clk);
    #1;
    check_output("rst_cnt_clr", 32'(cnt_clr), 32'd0);
    check_output("rst_ref_gate", 32'(ref_gate), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_timeout_err", 32'(timeout_err), 32'd0);
    check_output("rst_sig_out", sig_cnt_out, 32'd0);
    check_output("rst_ref_out", ref_cnt_out, 32'd0);
    check_output("rst_idx_out", 32'(gate_idx_out), 32'd0);
    rst_n = 1'b1;
    @(posedge sys_clk);
    #1;

    // Manual measurement with start-to-clear and clear-to-gate latency.
    $display("[TB] manual gate_sel=1 latency sequence");
    for (int i = 0; i < 4; i++) sig_tab[i] = 500;
    clear_mon();
    apply_stimulus(2'd1, 1'b0, 1'b0);
    check_output("lat_cnt_clr_hi", 32'(cnt_clr), 32'd1);
    check_output("lat_ref_gate_lo", 32'(ref_gate), 32'd0);
    check_output("lat_busy", 32'(busy), 32'd1);
    @(posedge sys_clk);
    #1;
    check_output("lat_cnt_clr_lo", 32'(cnt_clr), 32'd0);
    check_output("lat_ref_gate_hi", 32'(ref_gate), 32'd1);
    wait_done("lat_wait");
    check_output("lat_done_cnt", 32'(done_cnt), 32'd1);
    check_output("lat_win", 32'(win_q.size() > 0 ? win_q[0] : 0), 32'd32);
    check_output("lat_sig", sig_cnt_out, 32'd500);
    check_output("lat_idx", 32'(gate_idx_out), 32'd1);

    // Table-driven measurements.
    for (int v = 0; v < 8; v++) begin
      sig_tab[0] = vecs[v].s0; sig_tab[1] = vecs[v].s1;
      sig_tab[2] = vecs[v].s2; sig_tab[3] = vecs[v].s3;
      rg_delay = v % 4;
      run_vector($sformatf("vec%0d", v), vecs[v].gsel, vecs[v].au,
                 vecs[v].exp_idx, vecs[v].exp_sig, vecs[v].exp_win);
    end

    // Start while busy must not disturb the running measurement.
    for (int i = 0; i < 4; i++) sig_tab[i] = 500;
    clear_mon();
    apply_stimulus(2'd1, 1'b0, 1'b0);
    repeat (5) @(posedge sys_clk);
    #1;
    gate_sel = 2'd3; start = 1'b1;
    @(posedge sys_clk);
    #1;
    start = 1'b0;
    wait_done("busy_start_wait");
    check_output("busy_start_done", 32'(done_cnt), 32'd1);
    check_output("busy_start_idx", 32'(gate_idx_out), 32'd1);
    check_output("busy_start_windows", 32'(win_q.size()), 32'd1);

    // Start in the same cycle as done is ignored.
    clear_mon();
    apply_stimulus(2'd0, 1'b0, 1'b0);
    n = 0;
    while (done !== 1'b1 && n < 1000) begin
      @(negedge sys_clk);
      n++;
    end
    if (done !== 1'b1) bound_expired("start_on_done_wait");
    gate_sel = 2'd2; start = 1'b1;
    @(posedge sys_clk);
    #1;
    start = 1'b0;
    check_output("start_on_done_busy", 32'(busy), 32'd0);
    check_output("start_on_done_clr", 32'(cnt_clr), 32'd0);

    // Randomized measurements against the reference model.
    for (int r = 0; r < 15; r++) begin
      for (int i = 0; i < 4; i++) sig_tab[i] = int'($urandom_range(0, 250));
      gs = 2'($urandom_range(0, 3));
      au = 1'($urandom_range(0, 1));
      rg_delay = int'($urandom_range(0, 3));
      n = model_idx(au, gs);
      run_vector($sformatf("rnd%0d", r), gs, au, n, sig_tab[n], n - (au ? 0 : int'(gs)) + 1);
    end

    // Continuous mode, then abort with stop in the middle of a gate.
    $display("[TB] continuous mode with stop");
    for (int i = 0; i < 4; i++) sig_tab[i] = 300;
    rg_delay = 1;
    clear_mon();
    apply_stimulus(2'd0, 1'b0, 1'b1);
    n = 0;
    while (done_cnt < 3 && n < 3000) begin
      @(negedge sys_clk);
      n++;
    end
    if (done_cnt < 3) bound_expired("cont_wait");
    check_output("cont_clr_order", 32'(clr_order_bad), 32'd0);
    check_output("cont_win0", 32'(win_q.size() > 0 ? win_q[0] : 0), 32'd8);
    check_output("cont_win2", 32'(win_q.size() > 2 ? win_q[2] : 0), 32'd8);
    wait_level(1'b1, "cont_gate_wait");
    @(posedge sys_clk);
    #1;
    stop = 1'b1;
    @(posedge sys_clk);
    #1;
    check_output("stop_ref_gate", 32'(ref_gate), 32'd0);
    check_output("stop_busy", 32'(busy), 32'd0);
    d_before = done_cnt;
    start = 1'b1;
    @(posedge sys_clk);
    #1;
    start = 1'b0; stop = 1'b0;
    check_output("stop_start_ignored", 32'(busy), 32'd0);
    repeat (30) @(posedge sys_clk);
    #1;
    check_output("stop_no_done", 32'(done_cnt), 32'(d_before));
    check_output("stop_hold_sig", sig_cnt_out, 32'd300);
    check_output("stop_hold_ref", ref_cnt_out, 32'd8);
    check_output("stop_hold_idx", 32'(gate_idx_out), 32'd0);

    // Timeout: real_gate stuck high after the gate closes.
    $display("[TB] timeout sequence");
    force_rg = 1'b1;
    rg_delay = 0;
    clear_mon();
    apply_stimulus(2'd0, 1'b0, 1'b0);
    wait_level(1'b1, "to_gate_rise");
    wait_level(1'b0, "to_gate_fall");
    n = 0;
    while (timeout_err !== 1'b1 && n < 100) begin
      @(negedge sys_clk);
      n++;
    end
    check_output("to_close_cycles", 32'(n), 32'(TIMEOUT));
    check_output("to_busy_in_err", 32'(busy), 32'd1);
    @(negedge sys_clk);
    check_output("to_busy_after", 32'(busy), 32'd0);
    check_output("to_err_sticky", 32'(timeout_err), 32'd1);
    check_output("to_no_done", 32'(done_cnt), 32'd0);
    check_output("to_hold_sig", sig_cnt_out, 32'd300);
    force_rg = 1'b0;
    @(posedge sys_clk);
    #1;
    apply_stimulus(2'd0, 1'b0, 1'b0);
    check_output("to_err_cleared", 32'(timeout_err), 32'd0);
    wait_done("to_recover_wait");
    check_output("to_recover_sig", sig_cnt_out, 32'd300);

    // Reset in the middle of SETTLE, with start held during reset.
    $display("[TB] reset during settle");
    for (int i = 0; i < 4; i++) sig_tab[i] = 777;
    clear_mon();
    apply_stimulus(2'd0, 1'b0, 1'b0);
    wait_level(1'b1, "rs_gate_rise");
    wait_level(1'b0, "rs_gate_fall");
    @(posedge sys_clk);
    @(posedge sys_clk);
    #1;
    rst_n = 1'b0; start = 1'b1;
    @(posedge sys_clk);
    #1;
    check_output("rs_cnt_clr", 32'(cnt_clr), 32'd0);
    check_output("rs_ref_gate", 32'(ref_gate), 32'd0);
    check_output("rs_busy", 32'(busy), 32'd0);
    check_output("rs_done", 32'(done), 32'd0);
    check_output("rs_timeout_err", 32'(timeout_err), 32'd0);
    check_output("rs_sig_out", sig_cnt_out, 32'd0);
    check_output("rs_ref_out", ref_cnt_out, 32'd0);
    check_output("rs_idx_out", 32'(gate_idx_out), 32'd0);
    rst_n = 1'b1; start = 1'b0;
    clear_mon();
    repeat (20) @(posedge sys_clk);
    #1;
    check_output("rs_no_done", 32'(done_cnt), 32'd0);
    check_output("rs_no_clr", 32'(clr_cnt), 32'd0);
    check_output("rs_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/freq_meas_ctrl.md
FREQ_MEAS_CTRL -- requirements
Module: freq_meas_ctrl

Interface
REQ-001 Parameter GATE_UNIT, default 2_000_000, sets the gate length for index 0 in sys_clk cycles (10 ms at 200 MHz).
REQ-002 Parameter TIMEOUT, default 400_000_000, is the maximum number of cycles to wait for real_gate to close.
REQ-003 Parameter SETTLE_CYC, default 16, is the number of cycles to wait after real_gate closes before sampling counts.
REQ-004 Parameter MIN_CNT, default 1000, is the auto-range threshold on sig_cnt.
REQ-005 sys_clk  in  1  sole clock; all logic on its rising edge.
REQ-006 rst_n  in  1  reset; synchronous, active-low.
REQ-007 start  in  1  one-cycle measurement request; ignored while busy=1.
REQ-008 stop  in  1  abort request; level-sampled every cycle.
REQ-009 cont  in  1  continuous mode; sampled together with start.
REQ-010 auto_range  in  1  enables auto gate ranging; sampled together with start.
REQ-011 gate_sel  in  2  manual gate index; sampled together with start.
REQ-012 real_gate  in  1  edge-synchronised gate returned by the counter datapath.
REQ-013 sig_cnt  in  32  signal edge count from the datapath.
REQ-014 ref_cnt  in  32  reference clock count from the datapath.
REQ-015 cnt_clr  out  1  one-cycle clear pulse to the datapath counters.
REQ-016 ref_gate  out  1  preset gate to the datapath.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 done  out  1  one-cycle result-valid pulse.
REQ-019 timeout_err  out  1  sticky timeout flag; cleared by accepted start or by reset.
REQ-020 sig_cnt_out, ref_cnt_out  out  32 each  captured counts.
REQ-021 gate_idx_out  out  2  gate index used for the captured result.

Function
REQ-022 Gate length SHALL be GATE_UNIT << (2*gate_idx), i.e. x1/x4/x16/x64; the gate counter SHALL be at least 32 bits wide.
REQ-023 FSM states SHALL be IDLE, CLEAR, GATE, CLOSE, SETTLE, EVAL and ERR, with all outputs registered.
REQ-024 IDLE: start=1 SHALL latch cont and auto_range, set gate_idx to 0 if auto_range is set (otherwise to gate_sel), clear timeout_err, and go to CLEAR.
REQ-025 CLEAR: cnt_clr SHALL be 1 for exactly this one cycle, then the FSM goes to GATE.
REQ-026 GATE: ref_gate SHALL be 1 for exactly the gate length in cycles, then the FSM goes to CLOSE.
REQ-027 Latency: with start high at edge k, cnt_clr SHALL be high in cycle k+1 and ref_gate SHALL rise at edge k+2.
REQ-028 CLOSE: ref_gate SHALL be 0. When real_gate=0 the FSM goes to SETTLE. If TIMEOUT cycles elapse first, the FSM goes to ERR.
REQ-029 SETTLE: the FSM SHALL wait SETTLE_CYC cycles, then go to EVAL.
REQ-030 EVAL, retry case: if auto is latched, sig_cnt < MIN_CNT and gate_idx < 3, the FSM SHALL increment gate_idx and go to CLEAR, with no done pulse.
REQ-031 EVAL, result case: otherwise the FSM SHALL capture sig_cnt, ref_cnt and gate_idx into the outputs and pulse done in the next cycle, with the new outputs valid in that same cycle.
REQ-032 After done: if cont is latched and stop=0, the FSM goes to CLEAR (gate_idx reset to 0 if auto is latched); otherwise it goes to IDLE.
REQ-033 ERR: timeout_err SHALL be set, the FSM goes to IDLE next cycle, and no done pulse is issued.
REQ-034 stop=1 in any non-IDLE state SHALL force IDLE on the next edge, drop ref_gate that edge and issue no done; stop has priority over all other transitions.
REQ-035 Captured outputs SHALL hold until the next done; they are not changed by abort or timeout.
REQ-036 A start asserted in the same cycle as done or stop SHALL be ignored.
REQ-037 sig_cnt = 0 at EVAL with gate_idx = 3 SHALL still produce done, with sig_cnt_out = 0.

Reset
REQ-038 With rst_n=0 at a clock edge, the block SHALL enter IDLE and clear every output to 0: cnt_clr, ref_gate, busy, done, timeout_err, both count outputs and gate_idx_out.
REQ-039 Reset mid-measurement SHALL take effect on that edge, with no done pulse and no cnt_clr pulse.

Verification (GATE_UNIT=8, TIMEOUT=32, SETTLE_CYC=4, MIN_CNT=100)
REQ-040 Manual: gate_sel=1, start at edge 0, datapath model returns sig_cnt=500 -> cnt_clr high in cycle 1; ref_gate high for exactly 32 cycles from edge 2; done once with sig_cnt_out=500, gate_idx_out=1.
REQ-041 Auto-range: auto_range=1, model returns sig_cnt=10 at indices 0–1 and 200 at index 2 -> three ref_gate windows of 8, 32 and 128 cycles; a single done with gate_idx_out=2.
REQ-042 Timeout: real_gate held at 1 -> timeout_err=1 after 32 CLOSE cycles; no done; busy=0 next cycle; the next start clears timeout_err.
REQ-043 Continuous mode plus stop: cont=1 -> done pulses repeat with cnt_clr before each gate; stop mid-GATE -> ref_gate=0 and busy=0 one edge later; outputs hold the last result.
REQ-044 Reset mid-SETTLE: rst_n=0 for one edge -> all outputs 0 on that edge; a start while busy or during reset is ignored.
